// File: rtl/i2c_slave.sv
// Byte-write I2C responder: START, ID, ACK, ADDR, ACK, DATA, ACK, STOP into a local register file.
// Optional I2C_SLV_GLITCH_FILT_EN adds a 3-sample majority filter after each synchronizer.
module i2c_slave #(
  parameter logic [7:0] DEV_ID      = 8'hA0,
  parameter int         REG_AW      = 5,
  parameter int         RELEASE_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic              wr_vld,
  output logic [7:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam int unsigned DEPTH = 2 ** REG_AW;
  localparam int          HW    = $clog2(RELEASE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ID, ACK_ID, ADDR, ACK_ADDR, DATA, ACK_DATA, IGNORE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [7:0]  sh, sh_n, addr_q, addr_n, wdata;
  logic        done, done_n, drive, drive_n, busy_n, we;
  logic [HW-1:0] hi_cnt;
  logic [7:0]  mem [DEPTH];

  logic scl_s1, scl_s2, sda_s1, sda_s2, scl_c, sda_c, scl_p, sda_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {scl_s1, scl_s2, sda_s1, sda_s2} <= '1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_SLV_GLITCH_FILT_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_f, sda_f;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_h <= '1;
      sda_h <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_s2};
      sda_h <= {sda_h[0], sda_s2};
      scl_f <= maj3(scl_s2, scl_h[0], scl_h[1]);
      sda_f <= maj3(sda_s2, sda_h[0], sda_h[1]);
    end
  end

  assign scl_c = scl_f;
  assign sda_c = sda_f;
`else
  assign scl_c = scl_s2;
  assign sda_c = sda_s2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p  <= 1'b1;
      sda_p  <= 1'b1;
      hi_cnt <= '0;
    end else begin
      scl_p <= scl_c;
      sda_p <= sda_c;
      if (!scl_c)
        hi_cnt <= '0;
      else if (hi_cnt != HW'(RELEASE_CYC))
        hi_cnt <= hi_cnt + 1'b1;
    end
  end

  wire scl_rise = scl_c & ~scl_p;
  wire scl_fall = ~scl_c & scl_p;
  wire start    = scl_c & scl_p & sda_p & ~sda_c;
  wire stop     = scl_c & scl_p & ~sda_p & sda_c;
  wire timeout  = (hi_cnt == HW'(RELEASE_CYC));

  assign wdata = {sh[6:0], sda_c};

  // A byte is shifted on 8 rises, then judged on the following fall, which also opens the ACK slot.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    done_n  = done;
    drive_n = drive;
    busy_n  = busy;
    addr_n  = addr_q;
    we      = 1'b0;
    if (start) begin
      state_n = ID;
      cnt_n   = '0;
      done_n  = 1'b0;
      drive_n = 1'b0;
      busy_n  = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      done_n  = 1'b0;
      drive_n = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        ID, ADDR, DATA: begin
          if (scl_rise && !done) begin
            sh_n  = wdata;
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              done_n = 1'b1;
              we     = (state == DATA);
            end
          end else if (scl_fall && done) begin
            done_n  = 1'b0;
            drive_n = 1'b1;
            if (state == ID) begin
              state_n = (sh == DEV_ID) ? ACK_ID : IGNORE;
              drive_n = (sh == DEV_ID);
            end else if (state == ADDR) begin
              addr_n  = sh;
              state_n = ACK_ADDR;
            end else begin
              state_n = ACK_DATA;
            end
          end
        end
        ACK_ID, ACK_ADDR, ACK_DATA: begin
          if (scl_fall) begin
            drive_n = 1'b0;
            state_n = (state == ACK_ID) ? ADDR : (state == ACK_ADDR) ? DATA : IGNORE;
          end else if (timeout) begin
            drive_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      done   <= 1'b0;
      drive  <= 1'b0;
      busy   <= 1'b0;
      addr_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      done   <= done_n;
      drive  <= drive_n;
      busy   <= busy_n;
      addr_q <= addr_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_vld  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_vld <= we;
      if (we) begin
        wr_addr                   <= addr_q;
        wr_data                   <= wdata;
        mem[addr_q[REG_AW-1:0]] <= wdata;
      end
    end
  end

  assign rd_data = mem[rd_addr];
  assign sda     = drive ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master on an open-drain bus with pull-up.
module tb_i2c_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [4:0] rd_addr = '0;
  wire        sda_bus;
  wire        wr_vld, busy;
  wire  [7:0] wr_addr, wr_data, rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int exp_vld = 0;
  logic [2:0] ae, al;
  logic       ok;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_vld) vld_cnt <= vld_cnt + 1;

  i2c_slave #(.DEV_ID(8'hA0), .REG_AW(5), .RELEASE_CYC(64)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1 check(tag, rd_data, exp);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    tick(32); m_low = ~b;
    tick(32); scl = 1'b1;
    if (glitch) begin
      tick(30); scl = 1'b0;
      tick(1);  scl = 1'b1;
      tick(33);
    end else tick(64);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, input int hold,
                           output logic ack_e, output logic ack_l);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == gbit);
    tick(32); m_low = 1'b0;
    tick(32); scl = 1'b1;
    tick(32); ack_e = sda_bus;
    tick(hold - 42); ack_l = sda_bus;
    tick(10); scl = 1'b0;
  endtask

  task automatic do_start();
    if (!scl) begin
      tick(32); m_low = 1'b0;
      tick(32); scl = 1'b1;
      tick(32);
    end
    m_low = 1'b1;
    tick(64); scl = 1'b0;
  endtask

  task automatic do_stop();
    tick(32); m_low = 1'b1;
    tick(32); scl = 1'b1;
    tick(32); m_low = 1'b0;
    tick(64);
  endtask

  task automatic frame(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                       input int gbit, input int hold,
                       output logic [2:0] ack_e, output logic [2:0] ack_l);
    do_start();
    send_byte(id, -1, 64, ack_e[2], ack_l[2]);
    send_byte(a, -1, 64, ack_e[1], ack_l[1]);
    send_byte(d, gbit, hold, ack_e[0], ack_l[0]);
    do_stop();
  endtask

  initial begin
    tick(5);
    #1;
    check("rst_wr_vld", {7'd0, wr_vld}, 8'h00);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_sda", {7'd0, sda_bus}, 8'h01);
    check_rd("rst_mem5", 5'd5, 8'h00);
    rst = 1'b1;
    tick(20);

    // nominal write
    do_start();
    tick(8);
    check("busy_in_frame", {7'd0, busy}, 8'h01);
    send_byte(8'hA0, -1, 64, ae[2], al[2]);
    send_byte(8'h05, -1, 64, ae[1], al[1]);
    send_byte(8'h3C, -1, 64, ae[0], al[0]);
    do_stop();
    exp_vld++;
    check("nom_ack_early", {5'd0, ae}, 8'h00);
    check("nom_ack_late", {5'd0, al}, 8'h00);
    check("nom_vld_cnt", 8'(vld_cnt), 8'(exp_vld));
    check("nom_wr_addr", wr_addr, 8'h05);
    check("nom_wr_data", wr_data, 8'h3C);
    check_rd("nom_mem5", 5'd5, 8'h3C);
    check("nom_busy_after", {7'd0, busy}, 8'h00);
    check("nom_sda_idle", {7'd0, sda_bus}, 8'h01);

    // ID mismatch
    frame(8'hA2, 8'h07, 8'h77, -1, 64, ae, al);
    check("mis_ack", {5'd0, ae}, 8'h07);
    check("mis_vld_cnt", 8'(vld_cnt), 8'(exp_vld));
    check_rd("mis_mem7", 5'd7, 8'h00);
    check("mis_busy", {7'd0, busy}, 8'h00);

    // address wrap
    frame(8'hA0, 8'h25, 8'h99, -1, 64, ae, al);
    exp_vld++;
    check("wrap_vld_cnt", 8'(vld_cnt), 8'(exp_vld));
    check_rd("wrap_mem5", 5'd5, 8'h99);
    check("wrap_wr_addr", wr_addr, 8'h25);

    // back-to-back frames
    frame(8'hA0, 8'h03, 8'h11, -1, 64, ae, al);
    exp_vld++;
    check_rd("b2b_mem3_first", 5'd3, 8'h11);
    frame(8'hA0, 8'h03, 8'h22, -1, 64, ae, al);
    exp_vld++;
    check("b2b_vld_cnt", 8'(vld_cnt), 8'(exp_vld));
    check_rd("b2b_mem3", 5'd3, 8'h22);

    // ACK held with scl high: force-release after RELEASE_CYC
    frame(8'hA0, 8'h01, 8'h42, -1, 200, ae, al);
    exp_vld++;
    check("to_ack_low", {7'd0, ae[0]}, 8'h00);
    check("to_ack_released", {7'd0, al[0]}, 8'h01);
    check_rd("to_mem1", 5'd1, 8'h42);

    // repeated START aborts partial data byte
    do_start();
    send_byte(8'hA0, -1, 64, ae[2], al[2]);
    send_byte(8'h0A, -1, 64, ae[1], al[1]);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("rs_no_write", 8'(vld_cnt), 8'(exp_vld));
    do_start();
    send_byte(8'hA0, -1, 64, ae[2], al[2]);
    send_byte(8'h0A, -1, 64, ae[1], al[1]);
    send_byte(8'h77, -1, 64, ae[0], al[0]);
    do_stop();
    exp_vld++;
    check("rs_vld_cnt", 8'(vld_cnt), 8'(exp_vld));
    check("rs_wr_data", wr_data, 8'h77);
    check_rd("rs_mem10", 5'd10, 8'h77);

    // reset during ADDR
    do_start();
    send_byte(8'hA0, -1, 64, ae[2], al[2]);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    tick(10); m_low = 1'b0;
    rst = 1'b0;
    #1;
    check("mr_sda", {7'd0, sda_bus}, 8'h01);
    check("mr_wr_vld", {7'd0, wr_vld}, 8'h00);
    check("mr_wr_addr", wr_addr, 8'h00);
    check("mr_wr_data", wr_data, 8'h00);
    check("mr_busy", {7'd0, busy}, 8'h00);
    check_rd("mr_mem3", 5'd3, 8'h00);
    tick(5);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    do_stop();
    check("mr_no_write", 8'(vld_cnt), 8'(exp_vld));
    frame(8'hA0, 8'h05, 8'h5A, -1, 64, ae, al);
    exp_vld++;
    check("mr_vld_cnt", 8'(vld_cnt), 8'(exp_vld));
    check_rd("mr_mem5", 5'd5, 8'h5A);

    // 1-clk low glitch on scl during data bit 3
    frame(8'hA0, 8'h06, 8'h5A, 3, 64, ae, al);
    ok = (vld_cnt == exp_vld + 1) && (wr_data == 8'h5A);
`ifdef I2C_SLV_GLITCH_FILT_EN
    check("glitch_filtered", {7'd0, ok}, 8'h01);
    check_rd("glitch_mem6", 5'd6, 8'h5A);
`else
    check("glitch_corrupts", {7'd0, ok}, 8'h00);
`endif
    check("glitch_busy", {7'd0, busy}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
